alu_mc_sequencer: RTL and testbench
===================================

Name: alu_mc_sequencer

Overview:
Shares one ALU instance between two requesters (req0 = core issue, req1 = secondary/coprocessor path) using a valid/ready request port and a one-cycle response pulse per requester.
Latches the operands, drives the ALU opcode and inputs stable for the whole operation, and pulses alu_start for the multi-cycle ops (mult 5'b00010, div 5'b00011).
Waits for alu_valid on multi-cycle ops, with a timeout guard, then returns the result to the granted requester.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 64, max cycles in WAIT before an error response (legal range 2..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 accepted this cycle when req0_valid=1
req0_op  in  5  requester 0 ALU opcode
req0_a  in  WIDTH  requester 0 operand 1
req0_b  in  WIDTH  requester 0 operand 2
rsp0_valid  out  1  one-cycle response pulse to requester 0
rsp0_data  out  WIDTH  result to requester 0
rsp0_err  out  1  illegal opcode or timeout
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as req0, requester 1
rsp1_valid, rsp1_data, rsp1_err  same as rsp0, requester 1
alu_opcode  out  5  to ALU opcode
alu_in1  out  WIDTH  to ALU alu_in1
alu_in2  out  WIDTH  to ALU alu_in2
alu_start  out  1  to ALU alu_start
alu_result  in  WIDTH  from ALU result
alu_valid  in  1  from ALU valid (multi-cycle ops only)

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0 (req0 favoured first), all outputs 0, alu_opcode=5'b00000, operand registers 0, timeout counter 0.
- State machine: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
- IDLE: grant is combinational round-robin.
  - Only one valid: grant it.
  - Both valid: grant the requester other than the last-granted one.
  - reqN_ready=1 only for the granted requester, only in IDLE; all ready outputs are 0 in every other state.
  - On accept (valid & ready): latch op, a, b and the owner id, update the rr pointer, go to ISSUE.
- ISSUE (1 cycle): alu_opcode/alu_in1/alu_in2 driven from the latched registers. They stay constant from ISSUE through RESP.
  - Legal single-cycle op (00000, 00001, 00100..01110): capture alu_result this cycle, go to RESP.
  - Multi-cycle op (00010, 00011): alu_start=1 for exactly this cycle, clear the counter, go to WAIT.
  - Illegal op (01111..11111): no alu_start, data=0, err=1, go to RESP.
- WAIT: counter increments each cycle.
  - alu_valid=1: capture alu_result, err=0, go to RESP.
  - Else if counter reaches TIMEOUT-1: data=0, err=1, go to RESP.
  - alu_valid and timeout in the same cycle: alu_valid wins.
  - alu_start stays 0 in WAIT.
- RESP (1 cycle): rspN_valid=1 for the owner only; rspN_data and rspN_err are valid only while rspN_valid=1 and are 0 otherwise. There is no response back-pressure. Go to IDLE.
- Latency, accept edge at cycle T:
  - Single-cycle op: rsp_valid high in cycle T+2.
  - Multi-cycle op: rsp_valid high the cycle after alu_valid is sampled.
  - Throughput: one op per 3 cycles minimum.
- A requester may hold valid with changing payload while not ready; only the payload at accept is used.
- Reset mid-operation (any state): immediate return to IDLE, no rsp pulse, alu_start drops asynchronously.

Optional Feature:
Macro ALU_SEQ_STATS_EN.
- Defined: adds output ports stat_ops (32 bits, count of completed responses, wraps at 2^32) and stat_timeouts (16 bits, count of timeout responses, saturates at 16'hFFFF). Both reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Single add: req0 op=00000, a=5, b=7, accepted at T -> alu_start stays 0, rsp0_valid at T+2 with data=12, err=0; rsp1_valid stays 0.
2. Mult with ALU model valid 6 cycles after start: req1 op=00010, a=6, b=9 -> one alu_start pulse in ISSUE, rsp1_valid 1 cycle after alu_valid, data=54; alu_in1/alu_in2 stable throughout.
3. Contention: both valid continuously with rr=0 after reset -> accept order req0, req1, req0, req1; each requester gets exactly one rsp per accept.
4. Timeout: op=00011 with alu_valid never asserted, TIMEOUT=64 -> rsp err=1, data=0 after 64 WAIT cycles; with stats enabled, stat_timeouts=1.
5. Illegal op=10101 -> no alu_start, rsp at T+2 with err=1, data=0.
6. Reset asserted during WAIT -> all outputs 0 immediately, no rsp pulse; after release the next req0 add 1+1 returns 2 at T+2.

Source files
------------

// File: rtl/alu_mc_sequencer.sv
// alu_mc_sequencer: round-robin sharing of one ALU between two requesters.
// Optional stat_ops/stat_timeouts ports when ALU_SEQ_STATS_EN is defined.
module alu_mc_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_start,
`ifdef ALU_SEQ_STATS_EN
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_timeouts,
`endif
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e           state_q;
  logic             rr_q;
  logic             own_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             start_q;
  logic [15:0]      cnt_q;
  logic             rsp0_valid_q;
  logic [WIDTH-1:0] rsp0_data_q;
  logic             rsp0_err_q;
  logic             rsp1_valid_q;
  logic [WIDTH-1:0] rsp1_data_q;
  logic             rsp1_err_q;

  logic             idle;
  logic             gnt0;
  logic             gnt1;
  logic             acc;
  logic [4:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             fin;
  logic [WIDTH-1:0] fin_d;
  logic             fin_e;

  function automatic logic is_multi(input logic [4:0] op);
    return (op == 5'd2) || (op == 5'd3);
  endfunction

  function automatic logic is_single(input logic [4:0] op);
    return (op <= 5'd1) || ((op >= 5'd4) && (op <= 5'd14));
  endfunction

  // rr_q=0 favours req0 on a tie, rr_q=1 favours req1
  always_comb begin
    idle   = (state_q == S_IDLE);
    gnt0   = req0_valid & (~req1_valid | ~rr_q);
    gnt1   = req1_valid & (~req0_valid | rr_q);
    acc    = idle & (gnt0 | gnt1);
    sel_op = gnt1 ? req1_op : req0_op;
    sel_a  = gnt1 ? req1_a : req0_a;
    sel_b  = gnt1 ? req1_b : req0_b;
  end

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  // completion of the current op: result/err to be latched for RESP
  always_comb begin
    fin   = 1'b0;
    fin_d = '0;
    fin_e = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        if (!is_multi(op_q)) begin
          fin   = 1'b1;
          fin_d = is_single(op_q) ? alu_result : '0;
          fin_e = ~is_single(op_q);
        end
      end
      S_WAIT: begin
        if (alu_valid) begin
          fin   = 1'b1;
          fin_d = alu_result;
        end else if (cnt_q == TMO_LAST) begin
          fin   = 1'b1;
          fin_e = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // sequencer FSM with registered ALU and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rr_q         <= 1'b0;
      own_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (acc) begin
            own_q   <= gnt1;
            rr_q    <= ~gnt1;
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            start_q <= is_multi(sel_op);
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          if (!fin) state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
        end
        S_RESP: begin
          rsp0_valid_q <= 1'b0;
          rsp0_data_q  <= '0;
          rsp0_err_q   <= 1'b0;
          rsp1_valid_q <= 1'b0;
          rsp1_data_q  <= '0;
          rsp1_err_q   <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (fin) begin
        rsp0_valid_q <= ~own_q;
        rsp0_data_q  <= own_q ? '0 : fin_d;
        rsp0_err_q   <= ~own_q & fin_e;
        rsp1_valid_q <= own_q;
        rsp1_data_q  <= own_q ? fin_d : '0;
        rsp1_err_q   <= own_q & fin_e;
        state_q      <= S_RESP;
      end
    end
  end

  assign alu_opcode = op_q;
  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_start  = start_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_err   = rsp1_err_q;

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] ops_q;
  logic [15:0] tos_q;
  logic        to_hit;

  assign to_hit = (state_q == S_WAIT) & ~alu_valid & (cnt_q == TMO_LAST);

  // response counter wraps, timeout counter saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q <= '0;
      tos_q <= '0;
    end else begin
      if (state_q == S_RESP) ops_q <= ops_q + 32'd1;
      if (to_hit && tos_q != 16'hFFFF) tos_q <= tos_q + 16'd1;
    end
  end

  assign stat_ops      = ops_q;
  assign stat_timeouts = tos_q;
`endif

endmodule

// File: tb/tb_alu_mc_sequencer.sv
// tb_alu_mc_sequencer: directed scoreboard bench for alu_mc_sequencer.
// Includes an ALU model with programmable multi-cycle latency.
module tb_alu_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        alu_start;
  logic        alu_valid = 1'b0;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_timeouts;
`endif

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          kind;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   t0[$];
  int   t1[$];
  int   order[$];
  int   cyc = 0;
  int   last_av = -100;
  int   n_start = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   mc_delay = 6;
  int   mc_cnt = 0;

  alu_mc_sequencer #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_start(alu_start),
`ifdef ALU_SEQ_STATS_EN
    .stat_ops(stat_ops), .stat_timeouts(stat_timeouts),
`endif
    .alu_result(alu_result), .alu_valid(alu_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] alu_f(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a * b;
      5'd3:    return (b != 0) ? a / b : 32'hFFFF_FFFF;
      default: return (a ^ b) + {27'd0, op};
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_in1, alu_in2);

  // multi-cycle ALU: valid mc_delay cycles after start, never if 0
  always @(posedge clk) begin
    alu_valid <= 1'b0;
    if (alu_start) mc_cnt <= mc_delay;
    else if (mc_cnt > 0) begin
      mc_cnt <= mc_cnt - 1;
      if (mc_cnt == 1) alu_valid <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rsp_chk(input bit r, input logic v,
                         input logic [31:0] d, input logic e);
    ent_t x;
    int   t;
    string p;
    p = r ? "rsp1" : "rsp0";
    if (!v) begin
      chk({p, "_idle"}, {31'd0, e, d}, 64'd0);
      return;
    end
    if (r ? (q1.size() == 0) : (q0.size() == 0)) begin
      chk({p, "_unexpected"}, {63'd0, v}, 64'd0);
      return;
    end
    if (r) begin
      x = q1.pop_front();
      t = (t1.size() > 0) ? t1.pop_front() : -1000;
    end else begin
      x = q0.pop_front();
      t = (t0.size() > 0) ? t0.pop_front() : -1000;
    end
    chk({p, "_data"}, {32'd0, d}, {32'd0, x.d});
    chk({p, "_err"}, {63'd0, e}, {63'd0, x.e});
    case (x.kind)
      0: chk({p, "_lat"}, 64'(cyc - t), 64'd2);
      1: chk({p, "_lat_mc"}, 64'(cyc - last_av), 64'd1);
      default: chk({p, "_lat_to"}, 64'(cyc - t), 64'd66);
    endcase
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (req0_valid && req0_ready) begin
        t0.push_back(cyc);
        order.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        t1.push_back(cyc);
        order.push_back(1);
      end
      chk("ready_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (alu_valid) last_av = cyc;
      if (alu_start) n_start++;
      rsp_chk(1'b0, rsp0_valid, rsp0_data, rsp0_err);
      rsp_chk(1'b1, rsp1_valid, rsp1_data, rsp1_err);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {52'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
         rsp0_err, rsp1_err, alu_start, alu_opcode}, 64'd0);
    chk({tag, "_rdata"}, {rsp0_data, rsp1_data}, 64'd0);
    chk({tag, "_alu_in"}, {alu_in1, alu_in2}, 64'd0);
  endtask

  task automatic send(input bit r, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input int kind, input logic [31:0] ed,
                      input logic ee);
    ent_t x;
    bit   ok;
    ok = 1'b0;
    x.d = ed;
    x.e = ee;
    x.kind = kind;
    if (r) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", {63'd0, ok}, 64'd1);
    if (ok) begin
      if (r) q1.push_back(x);
      else q0.push_back(x);
    end
    @(posedge clk);
    #1;
    if (r) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   s;
    bit   ok;
    bit   w;
    ent_t x;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    s = n_start;
    send(1'b0, 5'd0, 32'd5, 32'd7, 0, 32'd12, 1'b0);
    wait_done(20);
    chk("t1_no_start", 64'(n_start - s), 64'd0);

    mc_delay = 6;
    s = n_start;
    send(1'b1, 5'd2, 32'd6, 32'd9, 1, 32'd54, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      chk("t2_stable", {alu_in1, alu_in2}, {32'd6, 32'd9});
      if (q1.size() == 0) break;
    end
    chk("t2_drain", 64'(q1.size()), 64'd0);
    @(posedge clk);
    #1;
    chk("t2_one_start", 64'(n_start - s), 64'd1);

    order.delete();
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1; req1_op = 5'd0; req1_a = 32'd20; req1_b = 32'd2;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("t3_accept", {63'd0, ok}, 64'd1);
      if (!ok) break;
      w = req1_ready;
      x.e = 1'b0;
      x.kind = 0;
      x.d = w ? req1_a + req1_b : req0_a + req0_b;
      if (w) q1.push_back(x);
      else q0.push_back(x);
      @(posedge clk);
      #1;
      if (w) req1_a = req1_a + 32'd100;
      else req0_a = req0_a + 32'd100;
    end
    req0_valid = 0;
    req1_valid = 0;
    wait_done(30);
    chk("t3_n_accepts", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk("t3_order", 64'(order[i]), 64'(i % 2));

    s = n_start;
    send(1'b0, 5'b10101, 32'd3, 32'd4, 0, 32'd0, 1'b1);
    wait_done(20);
    chk("t5_no_start", 64'(n_start - s), 64'd0);

    mc_delay = 0;
    send(1'b0, 5'd3, 32'd100, 32'd5, 2, 32'd0, 1'b1);
    wait_done(120);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_timeouts", {48'd0, stat_timeouts}, 64'd1);
    chk("stat_ops", {32'd0, stat_ops}, 64'd8);
`endif

    send(1'b1, 5'd3, 32'd8, 32'd2, 2, 32'd0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("midreset");
    q0.delete(); q1.delete(); t0.delete(); t1.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    mc_delay = 6;
    send(1'b0, 5'd0, 32'd1, 32'd1, 0, 32'd2, 1'b0);
    wait_done(20);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops_after_rst", {32'd0, stat_ops}, 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
